fetch_pc_redirect: RTL and testbench

//  Front-end PC generator and consumer of the branch unit's redirect request
//  (jb_enable / jb_target_pc). Issues sequential word-addressed fetch PCs and

---
 rtl/fetch_pc_redirect_pkg.sv | 16 +
 rtl/redirect_shadow_ctr.sv | 74 +++++++
 rtl/fetch_pc_redirect.sv | 79 +++++++
 tb/tb_fetch_pc_redirect.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/fetch_pc_redirect_pkg.sv
// Shared definitions for the fetch PC generator and the branch unit's PC delay line.
//   STATE_RUN / STATE_SHADOW : redirect-shadow state encodings
//   PC_WIDTH, RESET_PC, PC_STEP, FLUSH_DEPTH : default front-end geometry
package fetch_pc_redirect_pkg;

  localparam int unsigned PC_WIDTH    = 32;
  localparam int unsigned RESET_PC    = 0;
  localparam int unsigned PC_STEP     = 1;
  localparam int unsigned FLUSH_DEPTH = 3;

  typedef enum logic [0:0] {
    STATE_RUN    = 1'b0,
    STATE_SHADOW = 1'b1
  } state_e;

endpackage

// File: rtl/redirect_shadow_ctr.sv
// Redirect-shadow state machine: accepts a taken branch while in RUN and then
// ignores further requests for FLUSH_DEPTH non-stalled cycles.
//   clk, reset_n   : clock, async active-low reset
//   stall          : back-end hold, freezes the shadow counter
//   jb_enable      : taken-branch request
//   accept_c       : combinational, redirect accepted at this edge
//   in_shadow      : registered, shadow state active
//   flush_pulse    : registered, high for the one cycle after an accept
module redirect_shadow_ctr #(
  parameter int unsigned FLUSH_DEPTH = fetch_pc_redirect_pkg::FLUSH_DEPTH
) (
  input  logic clk,
  input  logic reset_n,
  input  logic stall,
  input  logic jb_enable,
  output logic accept_c,
  output logic in_shadow,
  output logic flush_pulse
);
  import fetch_pc_redirect_pkg::*;

  localparam int unsigned CNT_W = (FLUSH_DEPTH > 1) ? $clog2(FLUSH_DEPTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_DEPTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_shadow_q;
  logic             flush_pulse_q;

  // State, counter and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= STATE_RUN;
      cnt_q         <= '0;
      in_shadow_q   <= 1'b0;
      flush_pulse_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      in_shadow_q   <= (state_d == STATE_SHADOW);
      flush_pulse_q <= accept_c;
    end
  end

  // Next state; requests seen in SHADOW come from squashed younger branches
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept_c = 1'b0;
    case (state_q)
      STATE_RUN: begin
        if (jb_enable) begin
          accept_c = 1'b1;
          state_d  = STATE_SHADOW;
          cnt_d    = CNT_LOAD;
        end
      end
      STATE_SHADOW: begin
        if (!stall) begin
          if (cnt_q == '0) begin
            state_d = STATE_RUN;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      default: state_d = STATE_RUN;
    endcase
  end

  assign in_shadow   = in_shadow_q;
  assign flush_pulse = flush_pulse_q;

endmodule

// File: rtl/fetch_pc_redirect.sv
// Front-end PC generator: issues sequential word-addressed fetch PCs, loads the
// branch unit's target on a taken redirect and kills the wrong-path stages.
//   clk, reset_n   : clock, async active-low reset
//   stall          : back-end hold, PC does not advance
//   jb_enable      : taken-branch request
//   jb_target_pc   : redirect target, used unmodified
//   imem_addr      : address fetched this cycle
//   fetch_valid    : imem_addr carries a correct-path fetch
//   flush          : per-stage kill, one cycle after an accepted redirect
//   in_shadow      : redirect-shadow state active
//   redirect_cnt   : accepted redirects, wrapping
module fetch_pc_redirect #(
  parameter int unsigned           PC_WIDTH    = fetch_pc_redirect_pkg::PC_WIDTH,
  parameter logic [PC_WIDTH-1:0]   RESET_PC    = PC_WIDTH'(fetch_pc_redirect_pkg::RESET_PC),
  parameter int unsigned           PC_STEP     = fetch_pc_redirect_pkg::PC_STEP,
  parameter int unsigned           FLUSH_DEPTH = fetch_pc_redirect_pkg::FLUSH_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   stall,
  input  logic                   jb_enable,
  input  logic [PC_WIDTH-1:0]    jb_target_pc,
  output logic [PC_WIDTH-1:0]    imem_addr,
  output logic                   fetch_valid,
  output logic [FLUSH_DEPTH-1:0] flush,
  output logic                   in_shadow,
  output logic [15:0]            redirect_cnt
);

  localparam logic [PC_WIDTH-1:0] STEP = PC_WIDTH'(PC_STEP);

  logic                accept_c;
  logic                flush_pulse;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                fetch_valid_q;
  logic [15:0]         redirect_cnt_q;

  redirect_shadow_ctr #(
    .FLUSH_DEPTH (FLUSH_DEPTH)
  ) u_shadow (
    .clk         (clk),
    .reset_n     (reset_n),
    .stall       (stall),
    .jb_enable   (jb_enable),
    .accept_c    (accept_c),
    .in_shadow   (in_shadow),
    .flush_pulse (flush_pulse)
  );

  // PC next-state: redirect beats stall beats sequential advance
  always_comb begin
    pc_d = pc_q;
    if (accept_c) begin
      pc_d = jb_target_pc;
    end else if (!stall) begin
      pc_d = pc_q + STEP;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q           <= RESET_PC;
      fetch_valid_q  <= 1'b0;
      redirect_cnt_q <= '0;
    end else begin
      pc_q          <= pc_d;
      fetch_valid_q <= 1'b1;
      if (accept_c) begin
        redirect_cnt_q <= redirect_cnt_q + 16'd1;
      end
    end
  end

  assign imem_addr    = pc_q;
  assign fetch_valid  = fetch_valid_q;
  assign flush        = {FLUSH_DEPTH{flush_pulse}};
  assign redirect_cnt = redirect_cnt_q;

endmodule

// File: tb/tb_fetch_pc_redirect.sv
// Directed bench for fetch_pc_redirect with hand-computed expected values.
module tb_fetch_pc_redirect;

  logic        clk;
  logic        reset_n;
  logic        stall;
  logic        jb_enable;
  logic [31:0] jb_target_pc;
  logic [31:0] imem_addr;
  logic        fetch_valid;
  logic [2:0]  flush;
  logic        in_shadow;
  logic [15:0] redirect_cnt;

  int n_checks = 0;
  int n_fails  = 0;

  fetch_pc_redirect dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .stall        (stall),
    .jb_enable    (jb_enable),
    .jb_target_pc (jb_target_pc),
    .imem_addr    (imem_addr),
    .fetch_valid  (fetch_valid),
    .flush        (flush),
    .in_shadow    (in_shadow),
    .redirect_cnt (redirect_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and settle at the following falling edge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_all(input string tag, input logic [31:0] addr, input logic fv,
                           input logic [2:0] fl, input logic sh, input logic [15:0] cnt);
    check({tag, ".addr"},  imem_addr,           addr);
    check({tag, ".valid"}, 32'(fetch_valid),    32'(fv));
    check({tag, ".flush"}, 32'(flush),          32'(fl));
    check({tag, ".shadow"},32'(in_shadow),      32'(sh));
    check({tag, ".cnt"},   32'(redirect_cnt),   32'(cnt));
  endtask

  initial begin
    reset_n      = 1'b1;
    stall        = 1'b0;
    jb_enable    = 1'b0;
    jb_target_pc = '0;
    #1 reset_n = 1'b0;
    #1;
    check_all("reset", 32'h0, 1'b0, 3'b000, 1'b0, 16'd0);

    // Sequential fetch from RESET_PC
    @(negedge clk);
    reset_n = 1'b1;
    check("seq0.addr", imem_addr, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      step();
      check_all($sformatf("seq%0d", i), 32'(i), 1'b1, 3'b000, 1'b0, 16'd0);
    end
    step(); step(); step();
    check("pc7", imem_addr, 32'h7);

    // Taken redirect to 0x40, then younger redirects to 0x99 from the shadow
    jb_enable = 1'b1; jb_target_pc = 32'h40;
    step();
    check_all("redir", 32'h40, 1'b1, 3'b111, 1'b1, 16'd1);
    jb_target_pc = 32'h99;
    step();
    check_all("shad1", 32'h41, 1'b1, 3'b000, 1'b1, 16'd1);
    step();
    check_all("shad2", 32'h42, 1'b1, 3'b000, 1'b1, 16'd1);
    jb_enable = 1'b0;
    step();
    check_all("run43", 32'h43, 1'b1, 3'b000, 1'b0, 16'd1);

    // Redirect together with stall, stall held two more cycles
    stall = 1'b1; jb_enable = 1'b1; jb_target_pc = 32'h20;
    step();
    check_all("stredir", 32'h20, 1'b1, 3'b111, 1'b1, 16'd2);
    jb_enable = 1'b0;
    step();
    check_all("sthold1", 32'h20, 1'b1, 3'b000, 1'b1, 16'd2);
    step();
    check_all("sthold2", 32'h20, 1'b1, 3'b000, 1'b1, 16'd2);
    stall = 1'b0;
    step();
    check_all("stshad1", 32'h21, 1'b1, 3'b000, 1'b1, 16'd2);
    step();
    check_all("stshad2", 32'h22, 1'b1, 3'b000, 1'b1, 16'd2);
    step();
    check_all("strun", 32'h23, 1'b1, 3'b000, 1'b0, 16'd2);

    // Plain stall in RUN holds the PC
    stall = 1'b1;
    step();
    check("runstall.addr", imem_addr, 32'h23);
    stall = 1'b0;

    // PC wrap at all-ones
    jb_enable = 1'b1; jb_target_pc = 32'hFFFF_FFFF;
    step();
    check_all("pcmax", 32'hFFFF_FFFF, 1'b1, 3'b111, 1'b1, 16'd3);
    jb_enable = 1'b0;
    step();
    check("pcwrap.addr", imem_addr, 32'h0);
    step();
    check("pcwrap1.addr", imem_addr, 32'h1);
    step();
    check_all("pcwrap2", 32'h2, 1'b1, 3'b000, 1'b0, 16'd3);

    // Redirect counter wrap: preload the counter, then one redirect
    dut.redirect_cnt_q = 16'hFFFF;
    jb_enable = 1'b1; jb_target_pc = 32'h100;
    step();
    check_all("cntwrap", 32'h100, 1'b1, 3'b111, 1'b1, 16'd0);
    jb_enable = 1'b0;

    // Async reset while in SHADOW with flush asserted
    #2 reset_n = 1'b0;
    #1;
    check_all("rstshad", 32'h0, 1'b0, 3'b000, 1'b0, 16'd0);
    @(negedge clk);
    reset_n = 1'b1;
    step();
    check_all("postrst", 32'h1, 1'b1, 3'b000, 1'b0, 16'd0);
    jb_enable = 1'b1; jb_target_pc = 32'h55;
    step();
    check_all("postredir", 32'h55, 1'b1, 3'b111, 1'b1, 16'd1);
    jb_enable = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
